voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice allocator that sits between the note-event source (MIDI decoder or sequencer) and a bank of NUM_VOICES tone-generator/envelope_generator pairs. It accepts note-on/note-off events over a valid/ready handshake, assigns each note-on to a voice, and drives per-voice gate and note number. When every voice is busy it steals the least-recently-assigned voice and inserts a gate-low gap so the envelope re-enters attack cleanly.

## Interface
- NUM_VOICES, 4: number of voices; power of two, 2..8.
- NOTE_BITS, 7: note number width.
- GAP_CYCLES, 2: gate-low cycles inserted on steal/retrigger; 1..15.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_BITS  note number.
- voice_active  in  NUM_VOICES  per-voice envelope not OFF (amplitude ≠ 0).
- gate  out  NUM_VOICES  per-voice envelope gate.
- voice_note  out  NUM_VOICES*NOTE_BITS  per-voice note, voice i at [i*NOTE_BITS +: NOTE_BITS].

## Operation
- States: IDLE, SEARCH, GAP, ASSIGN.
- IDLE: ev_ready=1; on ev_valid&&ev_ready latch ev_on/ev_note, go SEARCH.
- SEARCH (one cycle, samples gate/voice_active/ages this cycle):
  - note-off: voice with gate=1 and matching note → gate low, go IDLE. No match → ignored, IDLE.
  - note-on, matching gated voice exists → retrigger that voice (treated as steal).
  - else first choice: lowest-index voice with gate=0 and voice_active=0.
  - else: gate=0 voice (releasing) with greatest age.
  - else: steal gated voice with greatest age.
  - Target gate=0 → ASSIGN. Target gate=1 → drop its gate, load new note, GAP.
- GAP: hold target gate low GAP_CYCLES cycles, then ASSIGN.
- ASSIGN: write voice_note[target], gate[target]=1, target age=0, every voice with age < old target age increments; go IDLE.
- Ages: LRU ranks 0 (newest)..NUM_VOICES-1 (oldest), always a permutation. Only note-on assignment changes ages.
- At most one gated voice per note (retrigger rule guarantees it).

## Timing
- Accept at cycle T; SEARCH at T+1.
- Free/releasing target: gate high and voice_note valid at T+2; ev_ready high at T+2.
- Steal/retrigger: gate low and new voice_note at T+2, gate high at T+2+GAP_CYCLES, ev_ready high same cycle.
- Note-off: gate low at T+2, ev_ready high at T+2.
- ev_ready=0 outside IDLE and while rst high; events are held by source, never dropped.
- voice_active changes during SEARCH: value sampled in SEARCH cycle wins.
- Reset values (immediate, asynchronous): state IDLE, gate all 0, voice_note all 0, age[i]=i, ev_ready 0 until rst deasserts.
- Reset mid-GAP/ASSIGN: pending event discarded; all gates low.

## Structure
- Shared header voice_defs.vh (include-guarded): state encodings, default NOTE_BITS, age width $clog2(NUM_VOICES).
- Sub-module voice_age_tracker: holds LRU ranks, ports touch/touch_idx, outputs packed ages and oldest-gated/oldest-released indices.
- Selection priority logic and FSM in voice_allocator.

## Test plan
- After reset, note-on 60, 62, 64, 65 (voice_active low) → voices 0..3 gated with 60/62/64/65, each gate rising 2 cycles after accept; ages 3,2,1,0.
- Fifth note-on 67, all gated → voice 0 gate low for 2 cycles, voice_note[0]=67 at T+2, gate[0] high at T+4; ev_ready low T+1..T+3.
- Note-off 62 with voice_active[1]=1, then note-on 70 with voices 0,2,3 gated → voice 1 (releasing) reused, no gap, gate at T+2.
- Note-on 64 while 64 held on voice 2 → voice 2 retriggered via 2-cycle gap, no other voice changes.
- Note-off 99 (not held) → no gate change, ev_ready back at T+2; ev_valid held high through busy cycles → accepted exactly once.
- Assert rst during GAP → all gates 0 immediately, ages 0..3 by index, next note-on lands on voice 0.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the polyphonic voice allocator: FSM states,
// default widths and the LRU rank width helper.
package voice_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_GAP    = 2'd2,
    ST_ASSIGN = 2'd3
  } state_e;

  localparam int DEFAULT_NOTE_BITS = 7;
  localparam int GAP_CNT_BITS      = 4;

  // Rank width is $clog2(NUM_VOICES), kept at least one bit wide.
  function automatic int age_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// LRU rank keeper: rank 0 is the newest assignment, NUM_VOICES-1 the oldest.
// Also reports the oldest gated and oldest released (gate low) voices.
module voice_age_tracker
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AW         = age_bits(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  touch,
  input  logic [AW-1:0]         touch_idx,
  input  logic [NUM_VOICES-1:0] gate,
  output logic [AW-1:0]         oldest_gated_idx,
  output logic [AW-1:0]         oldest_released_idx,
  output logic                  released_found
);

  logic [AW-1:0] age_q [NUM_VOICES];
  logic [AW-1:0] age_d [NUM_VOICES];
  logic [AW-1:0] g_best_age;
  logic [AW-1:0] r_best_age;
  logic          g_found;

  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) age_d[i] = age_q[i];
    if (touch) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + 1'b1;
      end
      age_d[touch_idx] = '0;
    end
  end

  // NOTE: the rank array is state, not storage, so each entry is reset to its index to start as a permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= AW'(i);
    end else begin
      // NOTE: non-blocking updates so every rank moves on the same edge from the same old values.
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    oldest_gated_idx    = '0;
    oldest_released_idx = '0;
    released_found      = 1'b0;
    g_found             = 1'b0;
    g_best_age          = '0;
    r_best_age          = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate[i] && (!g_found || age_q[i] > g_best_age)) begin
        g_found          = 1'b1;
        g_best_age       = age_q[i];
        oldest_gated_idx = AW'(i);
      end
      if (!gate[i] && (!released_found || age_q[i] > r_best_age)) begin
        released_found      = 1'b1;
        r_best_age          = age_q[i];
        oldest_released_idx = AW'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto voices, stealing
// the least-recently-assigned voice with a gate-low gap when all are busy.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = DEFAULT_NOTE_BITS,
  parameter int GAP_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]           voice_active,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note
);

  localparam int AW = age_bits(NUM_VOICES);
  // The ASSIGN cycle is the last gate-low cycle, so GAP itself lasts GAP_CYCLES-1.
  localparam logic [GAP_CNT_BITS-1:0] GAP_LOAD =
    GAP_CNT_BITS'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  state_e                  state_q, state_d;
  logic                    ev_on_q, ev_on_d;
  logic [NOTE_BITS-1:0]    ev_note_q, ev_note_d;
  logic [AW-1:0]           target_q, target_d;
  logic [GAP_CNT_BITS-1:0] gap_cnt_q, gap_cnt_d;
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [NOTE_BITS-1:0]    note_q [NUM_VOICES];
  logic [NOTE_BITS-1:0]    note_d [NUM_VOICES];

  logic                    touch;
  logic [AW-1:0]           touch_idx;
  logic [AW-1:0]           oldest_gated_idx, oldest_released_idx;
  logic                    released_found;
  logic                    match_hit, free_hit, steal;
  logic [AW-1:0]           match_idx, free_idx, sel_idx;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AW         (AW)
  ) u_age (
    .clk                 (clk),
    .rst                 (rst),
    .touch               (touch),
    .touch_idx           (touch_idx),
    .gate                (gate_q),
    .oldest_gated_idx    (oldest_gated_idx),
    .oldest_released_idx (oldest_released_idx),
    .released_found      (released_found)
  );

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_hit && gate_q[i] && note_q[i] == ev_note_q) begin
        match_hit = 1'b1;
        match_idx = AW'(i);
      end
      if (!free_hit && !gate_q[i] && !voice_active[i]) begin
        free_hit = 1'b1;
        free_idx = AW'(i);
      end
    end
  end

  // Retrigger beats a free voice so a note is never gated on two voices.
  always_comb begin
    if (match_hit) begin
      sel_idx = match_idx;
      steal   = 1'b1;
    end else if (free_hit) begin
      sel_idx = free_idx;
      steal   = 1'b0;
    end else if (released_found) begin
      sel_idx = oldest_released_idx;
      steal   = 1'b0;
    end else begin
      sel_idx = oldest_gated_idx;
      steal   = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    target_d  = target_q;
    gap_cnt_d = gap_cnt_q;
    gate_d    = gate_q;
    for (int i = 0; i < NUM_VOICES; i++) note_d[i] = note_q[i];
    touch     = 1'b0;
    touch_idx = target_q;

    case (state_q)
      ST_IDLE: begin
        if (ev_valid) begin
          ev_on_d   = ev_on;
          ev_note_d = ev_note;
          state_d   = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        state_d = ST_IDLE;
        if (!ev_on_q) begin
          if (match_hit) gate_d[match_idx] = 1'b0;
        end else begin
          target_d        = sel_idx;
          note_d[sel_idx] = ev_note_q;
          if (steal) begin
            gate_d[sel_idx] = 1'b0;
            gap_cnt_d       = GAP_LOAD;
            state_d         = (GAP_CYCLES > 1) ? ST_GAP : ST_ASSIGN;
          end else begin
            gate_d[sel_idx] = 1'b1;
            touch           = 1'b1;
            touch_idx       = sel_idx;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_ASSIGN;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      ST_ASSIGN: begin
        gate_d[target_q] = 1'b1;
        touch            = 1'b1;
        touch_idx        = target_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      target_q  <= '0;
      gap_cnt_q <= '0;
      gate_q    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) note_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      target_q  <= target_d;
      gap_cnt_q <= gap_cnt_d;
      gate_q    <= gate_d;
      for (int i = 0; i < NUM_VOICES; i++) note_q[i] <= note_d[i];
    end
  end

  assign ev_ready = (state_q == ST_IDLE) && !rst;
  assign gate     = gate_q;

  always_comb begin
    voice_note = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_note[i*NOTE_BITS +: NOTE_BITS] = note_q[i];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a queue/array reference model predicts
// each event's outcome; a monitor compares when the DUT returns to ready.
module tb_voice_allocator;

  localparam int NV  = 4;
  localparam int NB  = 7;
  localparam int GAP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_on;
  logic [NB-1:0]    ev_note;
  logic [NV-1:0]    voice_active;
  logic [NV-1:0]    gate;
  logic [NV*NB-1:0] voice_note;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES (NV),
    .NOTE_BITS  (NB),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .voice_active (voice_active),
    .gate         (gate),
    .voice_note   (voice_note)
  );

  typedef struct {
    logic [NV-1:0]    gate_mid;
    logic [NV-1:0]    gate_fin;
    logic [NV*NB-1:0] notes;
    int               lat;
  } exp_t;

  int   checks  = 0;
  int   errors  = 0;
  int   sent    = 0;
  int   accepts = 0;
  exp_t sb[$];

  // Reference model: per-voice gate/note plus a recency list, newest first.
  bit            m_gate [NV];
  logic [NB-1:0] m_note [NV];
  int            lru[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NV-1:0] m_gates();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_gate[v];
    return r;
  endfunction

  function automatic logic [NV*NB-1:0] m_notes();
    logic [NV*NB-1:0] r;
    for (int v = 0; v < NV; v++) r[v*NB +: NB] = m_note[v];
    return r;
  endfunction

  task automatic model_reset();
    lru.delete();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 1'b0;
      m_note[v] = '0;
      lru.push_back(v);
    end
  endtask

  task automatic predict(input bit on, input logic [NB-1:0] note);
    exp_t e;
    int   t     = -1;
    int   match = -1;
    int   idx   = -1;
    bit   stl   = 1'b0;
    for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == note) match = v;
    if (!on) begin
      if (match >= 0) m_gate[match] = 1'b0;
      e.lat = 2;
    end else begin
      if (match >= 0) begin
        t   = match;
        stl = 1'b1;
      end
      for (int v = 0; v < NV; v++) if (t < 0 && !m_gate[v] && !voice_active[v]) t = v;
      for (int p = lru.size() - 1; p >= 0; p--) if (t < 0 && !m_gate[lru[p]]) t = lru[p];
      if (t < 0) begin
        t   = lru[lru.size() - 1];
        stl = 1'b1;
      end
      m_note[t] = note;
      m_gate[t] = 1'b1;
      foreach (lru[p]) if (lru[p] == t) idx = p;
      lru.delete(idx);
      lru.push_front(t);
      e.lat = stl ? 2 + GAP : 2;
    end
    e.gate_fin = m_gates();
    e.gate_mid = e.gate_fin;
    if (stl) e.gate_mid[t] = 1'b0;
    e.notes = m_notes();
    sb.push_back(e);
  endtask

  task automatic check_ages();
    for (int p = 0; p < lru.size(); p++)
      check($sformatf("age_v%0d", lru[p]), 64'(dut.u_age.age_q[lru[p]]), 64'(p));
  endtask

  // Every send starts and ends just after a rising edge.
  task automatic send(input bit on, input logic [NB-1:0] note);
    int n = 0;
    predict(on, note);
    sent++;
    ev_on    = on;
    ev_note  = note;
    ev_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ev_ready && n < 60);
    check("send_ready", 64'(ev_ready), 64'd1);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ev_ready && n < 100);
    check("idle_ready", 64'(ev_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the prediction at accept, checks the T+2 view and the completion.
  initial begin
    exp_t cur;
    bit   busy = 1'b0;
    int   cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt++;
          if (cnt == 2) begin
            check("gate_t2", 64'(gate), 64'(cur.gate_mid));
            check("note_t2", 64'(voice_note), 64'(cur.notes));
          end
          if (ev_ready) begin
            check("latency", 64'(cnt), 64'(cur.lat));
            check("gate_done", 64'(gate), 64'(cur.gate_fin));
            check("note_done", 64'(voice_note), 64'(cur.notes));
            busy = 1'b0;
          end else if (cnt > 40) begin
            check("latency_timeout", 64'(cnt), 64'(cur.lat));
            busy = 1'b0;
          end
        end
        if (!busy && ev_valid && ev_ready) begin
          accepts++;
          check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            cur  = sb.pop_front();
            busy = 1'b1;
            cnt  = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    ev_valid     = 1'b0;
    ev_on        = 1'b0;
    ev_note      = '0;
    voice_active = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ev_ready), 64'd0);
    check("rst_gate", 64'(gate), 64'd0);
    check("rst_notes", 64'(voice_note), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(ev_ready), 64'd1);
    check_ages();
    @(posedge clk);
    #1;

    // Fill all four voices, then steal the oldest.
    send(1'b1, 7'd60);
    send(1'b1, 7'd62);
    send(1'b1, 7'd64);
    send(1'b1, 7'd65);
    wait_idle();
    check_ages();
    send(1'b1, 7'd67);
    wait_idle();
    check_ages();

    // Releasing voice is reused without a gap.
    voice_active = 4'b0010;
    send(1'b0, 7'd62);
    wait_idle();
    send(1'b1, 7'd70);
    wait_idle();

    // Retrigger of a held note, then an unmatched note-off held through busy.
    send(1'b1, 7'd64);
    send(1'b0, 7'd99);
    wait_idle();
    check_ages();

    // Reset during the steal gap.
    send(1'b1, 7'd61);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_gap_gate", 64'(gate), 64'd0);
    check("rst_gap_ready", 64'(ev_ready), 64'd0);
    check("rst_gap_notes", 64'(voice_note), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_ages();
    voice_active = '0;
    send(1'b1, 7'd72);
    wait_idle();
    check("after_rst_voice0", 64'(gate), 64'd1);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        check_ages();
        voice_active = NV'($urandom);
      end
      send($urandom_range(0, 9) < 7, NB'($urandom_range(60, 67)));
    end

    wait_idle();
    check_ages();
    check("accept_count", 64'(accepts), 64'(sent));
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
